seg7_scan_display: RTL

Displays the value produced by the up/down counter block on a multiplexed common-anode 7-segment display, one hex digit per anode.
- Time-multiplexes the digits with a programmable dwell time per digit.
- Takes a snapshot of the input value once per frame so that a digit never shows a half-updated value.
- Optionally blanks leading zeros.
- Sits between the counter and the board display pins.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_scan_display_hex_to_seg7.sv | 11 +
 rtl/seg7_scan_display.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: blank pattern, hex glyph table, FSM states.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph; zero latency, no flow control.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode hex display driver with per-frame snapshot and leading-zero blanking.
// Pins are registered one cycle behind the scan index; no backpressure, en_i low darkens the display.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int WIDTH_VALUE         = 8,
    parameter int NUM_DIGITS          = 2,
    parameter int SCAN_PERIOD         = 100_000,
    parameter int BLANK_LEADING_ZEROS = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic [WIDTH_VALUE-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]  dp_i,
    output logic [NUM_DIGITS-1:0]  anode_no,
    output logic [6:0]             seg_no,
    output logic                   dp_no,
    output logic                   frame_o
);

    localparam int TICK_W = $clog2(SCAN_PERIOD);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SNAP_W = NUM_DIGITS * 4;

    scan_state_e         r_state;
    logic [TICK_W-1:0]   r_tick;
    logic [IDX_W-1:0]    r_idx;
    logic [SNAP_W-1:0]   r_snap;

    scan_state_e         w_state_nxt;
    logic [TICK_W-1:0]   w_tick_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [SNAP_W-1:0]   w_snap_nxt;
    logic                w_frame_nxt;

    logic [SNAP_W-1:0]   w_value_ext;
    logic                w_tick_last;
    logic                w_idx_last;
    logic [3:0]          w_nib;
    logic                w_blank;
    logic                w_dp_req;
    logic [6:0]          w_seg;
    logic [NUM_DIGITS-1:0] w_anode_nxt;
    logic [6:0]          w_seg_nxt;
    logic                w_dp_nxt;

    assign w_value_ext = SNAP_W'(value_i);
    assign w_tick_last = (r_tick == TICK_W'(SCAN_PERIOD - 1));
    assign w_idx_last  = (r_idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_idx   <= '0;
            r_snap  <= '0;
            frame_o <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_idx   <= w_idx_nxt;
            r_snap  <= w_snap_nxt;
            frame_o <= w_frame_nxt;
        end
    end

    // Disable wins over the dwell-time wrap; snapshot is only refreshed when idx wraps to digit 0.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_idx_nxt   = r_idx;
        w_snap_nxt  = r_snap;
        w_frame_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_tick_nxt = '0;
                w_idx_nxt  = '0;
                if (en_i) begin
                    w_state_nxt = SCAN;
                    w_snap_nxt  = w_value_ext;
                    w_frame_nxt = 1'b1;
                end
            end
            SCAN: begin
                if (!en_i) begin
                    w_state_nxt = IDLE;
                    w_tick_nxt  = '0;
                    w_idx_nxt   = '0;
                end else if (w_tick_last) begin
                    w_tick_nxt = '0;
                    if (w_idx_last) begin
                        w_idx_nxt   = '0;
                        w_snap_nxt  = w_value_ext;
                        w_frame_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_nib    = 4'h0;
        w_blank  = 1'b0;
        w_dp_req = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib    = r_snap[4*k +: 4];
                w_dp_req = dp_i[k];
                w_blank  = (BLANK_LEADING_ZEROS != 0) && (k > 0) &&
                           ((r_snap >> (4*k)) == '0) && !dp_i[k];
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .i_hex (w_nib),
        .o_seg (w_seg)
    );

    always_comb begin
        w_anode_nxt = '1;
        w_seg_nxt   = SEG_OFF;
        w_dp_nxt    = 1'b1;
        if ((r_state == SCAN) && en_i && !w_blank) begin
            w_anode_nxt = ~(NUM_DIGITS'(1) << r_idx);
            w_seg_nxt   = w_seg;
            w_dp_nxt    = ~w_dp_req;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            anode_no <= '1;
            seg_no   <= SEG_OFF;
            dp_no    <= 1'b1;
        end else begin
            anode_no <= w_anode_nxt;
            seg_no   <= w_seg_nxt;
            dp_no    <= w_dp_nxt;
        end
    end

endmodule
